// File: rtl/sdrc_bank_arb.sv
// Bank arbiter: multiplexes the four bank FSM requests onto the single xfr_ctl
// command port with locked grants, round-robin fairness and ACT-to-ACT spacing.
module sdrc_bank_arb #(
  parameter int SDR_REQ_ID_W = 4,
  parameter int REQ_BW       = 7
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [3:0]                b2x_req,
  input  logic [7:0]                b2x_cmd,
  input  logic [47:0]               b2x_addr,
  input  logic [4*SDR_REQ_ID_W-1:0] b2x_id,
  input  logic [4*REQ_BW-1:0]       b2x_len,
  input  logic [3:0]                b2x_start,
  input  logic [3:0]                b2x_last,
  input  logic [3:0]                b2x_wrap,
  output logic [3:0]                x2b_ack,
  output logic                      a2x_req,
  output logic [1:0]                a2x_cmd,
  output logic [1:0]                a2x_ba,
  output logic [11:0]               a2x_addr,
  output logic [SDR_REQ_ID_W-1:0]   a2x_id,
  output logic [REQ_BW-1:0]         a2x_len,
  output logic                      a2x_start,
  output logic                      a2x_last,
  output logic                      a2x_wrap,
  input  logic                      x2a_ack,
  input  logic                      x2a_hold,
  input  logic                      cfg_cmd_pri,
  input  logic [3:0]                trrd_delay
);

  localparam logic [1:0] OP_PRE = 2'b00;
  localparam logic [1:0] OP_ACT = 2'b01;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_REQ  = 1'b1
  } arb_state_e;

  arb_state_e state_q, state_d;
  logic [1:0] gnt_q, gnt_d;
  logic [1:0] rr_ptr_q, rr_ptr_d;
  logic [3:0] trrd_cnt_q, trrd_cnt_d;

  logic [3:0] eligible;
  logic [3:0] row_cls;
  logic [3:0] cand;
  logic [1:0] win;
  logic       win_valid;
  logic       acked_act;

  // Eligibility and round-robin winner selection.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    eligible  = '0;
    row_cls   = '0;
    win       = rr_ptr_q;
    win_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      eligible[i] = b2x_req[i] &
                    ~((b2x_cmd[2*i +: 2] == OP_ACT) && (trrd_cnt_q != 4'd0));
      row_cls[i]  = eligible[i] &
                    ((b2x_cmd[2*i +: 2] == OP_PRE) || (b2x_cmd[2*i +: 2] == OP_ACT));
    end
    cand = (cfg_cmd_pri && (row_cls != 4'd0)) ? row_cls : eligible;
    // Walk offsets downwards so the one closest to rr_ptr is assigned last and wins.
    for (int k = 3; k >= 0; k--) begin
      if (cand[rr_ptr_q + 2'(k)]) begin
        win       = rr_ptr_q + 2'(k);
        win_valid = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    rr_ptr_d  = rr_ptr_q;
    a2x_req   = 1'b0;
    x2b_ack   = '0;
    acked_act = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (!x2a_hold && win_valid) begin
          gnt_d   = win;
          state_d = ARB_REQ;
        end
      end
      ARB_REQ: begin
        a2x_req = b2x_req[gnt_q];
        if (!b2x_req[gnt_q]) begin
          state_d = ARB_IDLE;
        end else if (x2a_ack) begin
          x2b_ack[gnt_q] = 1'b1;
          rr_ptr_d       = gnt_q + 2'd1;
          acked_act      = (b2x_cmd[2*gnt_q +: 2] == OP_ACT);
          state_d        = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase

    if (acked_act)                 trrd_cnt_d = trrd_delay;
    else if (trrd_cnt_q != 4'd0)   trrd_cnt_d = trrd_cnt_q - 4'd1;
    else                           trrd_cnt_d = 4'd0;
  end

  // Data fields follow the grant register; they are meaningless while idle.
  always_comb begin
    a2x_ba    = gnt_q;
    a2x_cmd   = b2x_cmd[2*gnt_q +: 2];
    a2x_addr  = b2x_addr[12*gnt_q +: 12];
    a2x_id    = b2x_id[SDR_REQ_ID_W*gnt_q +: SDR_REQ_ID_W];
    a2x_len   = b2x_len[REQ_BW*gnt_q +: REQ_BW];
    a2x_start = b2x_start[gnt_q];
    a2x_last  = b2x_last[gnt_q];
    a2x_wrap  = b2x_wrap[gnt_q];
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ARB_IDLE;
      gnt_q      <= 2'd0;
      rr_ptr_q   <= 2'd0;
      trrd_cnt_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      rr_ptr_q   <= rr_ptr_d;
      trrd_cnt_q <= trrd_cnt_d;
    end
  end

endmodule

// File: tb/tb_sdrc_bank_arb.sv
// Directed bench for sdrc_bank_arb: round-robin, tRRD spacing, command priority,
// withdrawal, hold and mid-grant reset, each with hand-computed expectations.
module tb_sdrc_bank_arb;

  localparam logic [1:0] OP_PRE = 2'b00;
  localparam logic [1:0] OP_ACT = 2'b01;
  localparam logic [1:0] OP_RD  = 2'b10;
  localparam logic [1:0] OP_WR  = 2'b11;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  b2x_req;
  logic [7:0]  b2x_cmd;
  logic [47:0] b2x_addr;
  logic [15:0] b2x_id;
  logic [27:0] b2x_len;
  logic [3:0]  b2x_start, b2x_last, b2x_wrap;
  logic [3:0]  x2b_ack;
  logic        a2x_req;
  logic [1:0]  a2x_cmd, a2x_ba;
  logic [11:0] a2x_addr;
  logic [3:0]  a2x_id;
  logic [6:0]  a2x_len;
  logic        a2x_start, a2x_last, a2x_wrap;
  logic        x2a_ack, x2a_hold, cfg_cmd_pri;
  logic [3:0]  trrd_delay;

  int n_checks = 0;
  int n_errors = 0;

  sdrc_bank_arb #(.SDR_REQ_ID_W(4), .REQ_BW(7)) dut (
    .clk(clk), .reset(reset),
    .b2x_req(b2x_req), .b2x_cmd(b2x_cmd), .b2x_addr(b2x_addr), .b2x_id(b2x_id),
    .b2x_len(b2x_len), .b2x_start(b2x_start), .b2x_last(b2x_last), .b2x_wrap(b2x_wrap),
    .x2b_ack(x2b_ack), .a2x_req(a2x_req), .a2x_cmd(a2x_cmd), .a2x_ba(a2x_ba),
    .a2x_addr(a2x_addr), .a2x_id(a2x_id), .a2x_len(a2x_len), .a2x_start(a2x_start),
    .a2x_last(a2x_last), .a2x_wrap(a2x_wrap), .x2a_ack(x2a_ack), .x2a_hold(x2a_hold),
    .cfg_cmd_pri(cfg_cmd_pri), .trrd_delay(trrd_delay)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change just after the falling edge; outputs are sampled 1 ns later.
  task automatic tick();
    @(negedge clk);
  endtask

  // One complete grant of a single bank with ack tied high; starts and ends in idle.
  task automatic do_single(input int bank, input logic [1:0] cmd);
    b2x_cmd[2*bank +: 2] = cmd;
    b2x_req = 4'b0001 << bank;
    x2a_ack = 1'b1;
    #1;
    check("single_idle_req", a2x_req, 0);
    tick(); #1;
    check("single_req", a2x_req, 1);
    check("single_ba", a2x_ba, bank);
    check("single_cmd", a2x_cmd, cmd);
    check("single_ack", x2b_ack, 4'b0001 << bank);
    check("single_id", a2x_id, bank + 8);
    check("single_len", a2x_len, 7'h10 + bank);
    check("single_flags", {a2x_start, a2x_last, a2x_wrap},
          {b2x_start[bank], b2x_last[bank], b2x_wrap[bank]});
    tick();
    b2x_req = 4'b0000;
  endtask

  initial begin
    reset       = 1'b1;
    b2x_req     = '0;
    b2x_cmd     = {OP_RD, OP_RD, OP_RD, OP_RD};
    b2x_addr    = {12'h103, 12'h102, 12'h101, 12'h100};
    b2x_id      = {4'd11, 4'd10, 4'd9, 4'd8};
    b2x_len     = {7'h13, 7'h12, 7'h11, 7'h10};
    b2x_start   = 4'b0101;
    b2x_last    = 4'b0011;
    b2x_wrap    = 4'b1001;
    x2a_ack     = 1'b0;
    x2a_hold    = 1'b0;
    cfg_cmd_pri = 1'b0;
    trrd_delay  = 4'd0;
    tick(); tick();
    reset = 1'b0;
    #1;
    check("rst_req", a2x_req, 0);
    check("rst_ack", x2b_ack, 0);
    check("rst_gnt", dut.gnt_q, 0);
    check("rst_rr", dut.rr_ptr_q, 0);
    check("rst_trrd", dut.trrd_cnt_q, 0);

    // All four banks read, ack tied high: grants 0,1,2,3,0, one ack every 2 cycles.
    b2x_req = 4'hF;
    x2a_ack = 1'b1;
    #1;
    for (int g = 0; g < 5; g++) begin
      check("t1_idle_req", a2x_req, 0);
      check("t1_idle_ack", x2b_ack, 0);
      tick(); #1;
      check("t1_req", a2x_req, 1);
      check("t1_ba", a2x_ba, g % 4);
      check("t1_ack_onehot", x2b_ack, 4'b0001 << (g % 4));
      check("t1_addr", a2x_addr, 12'h100 + (g % 4));
      check("t1_cmd", a2x_cmd, OP_RD);
      tick(); #1;
    end
    b2x_req = 4'b0000;
    check("t1_rr_after", dut.rr_ptr_q, 1);

    // Bank3 grant brings rr_ptr back to 0.
    do_single(3, OP_RD);
    #1;
    check("rr_wrap", dut.rr_ptr_q, 0);

    // Bank1 granted, ack low, bank withdraws.
    x2a_ack = 1'b0;
    b2x_req = 4'b0010;
    #1;
    tick(); #1;
    check("t4_req", a2x_req, 1);
    check("t4_ba", a2x_ba, 1);
    check("t4_noack", x2b_ack, 0);
    b2x_req = 4'b0000;
    #1;
    check("t4_withdraw_req", a2x_req, 0);
    check("t4_withdraw_ack", x2b_ack, 0);
    tick(); #1;
    check("t4_idle", dut.state_q, 0);
    check("t4_rr", dut.rr_ptr_q, 0);
    x2a_ack = 1'b1;   // ack with no request outstanding must be ignored
    #1;
    check("t4_stray_ack", x2b_ack, 0);
    tick(); #1;
    check("t4_stray_state", dut.state_q, 0);
    check("t4_stray_rr", dut.rr_ptr_q, 0);

    // Banks 0 and 1 ACT, tRRD=3: bank0 acked at T, bank1 requested at T+5.
    trrd_delay = 4'd3;
    b2x_cmd    = {OP_RD, OP_RD, OP_ACT, OP_ACT};
    b2x_req    = 4'b0011;
    #1;
    tick(); #1;
    check("t2_ba0", a2x_ba, 0);
    check("t2_ack0", x2b_ack, 4'b0001);
    tick();
    b2x_req = 4'b0010;
    #1;
    check("t2_trrd_load", dut.trrd_cnt_q, 3);
    for (int c = 0; c < 4; c++) begin
      check("t2_gap_req", a2x_req, 0);
      tick(); #1;
    end
    check("t2_req1", a2x_req, 1);
    check("t2_ba1", a2x_ba, 1);
    check("t2_cmd1", a2x_cmd, OP_ACT);
    check("t2_ack1", x2b_ack, 4'b0010);
    tick();
    b2x_req = 4'b0000;
    b2x_cmd = {OP_RD, OP_RD, OP_RD, OP_RD};
    #1;
    check("t2_rr", dut.rr_ptr_q, 2);
    do_single(3, OP_RD);

    // Priority: bank0 WR vs bank2 PRE with rr_ptr=0 -> bank2 first, then bank0.
    cfg_cmd_pri = 1'b1;
    b2x_cmd     = {OP_RD, OP_PRE, OP_RD, OP_WR};
    b2x_req     = 4'b0101;
    #1;
    check("t3_rr0", dut.rr_ptr_q, 0);
    tick(); #1;
    check("t3_ba2", a2x_ba, 2);
    check("t3_cmd_pre", a2x_cmd, OP_PRE);
    check("t3_ack2", x2b_ack, 4'b0100);
    tick();
    b2x_req = 4'b0001;
    #1;
    tick(); #1;
    check("t3_ba0", a2x_ba, 0);
    check("t3_cmd_wr", a2x_cmd, OP_WR);
    check("t3_ack0", x2b_ack, 4'b0001);
    tick();
    b2x_req     = 4'b0000;
    cfg_cmd_pri = 1'b0;
    b2x_cmd     = {OP_RD, OP_RD, OP_RD, OP_RD};

    // Hold blocks new grants but never aborts a locked one.
    x2a_hold = 1'b1;
    x2a_ack  = 1'b0;
    b2x_req  = 4'b0010;
    #1;
    tick(); #1;
    check("t5_hold_req_a", a2x_req, 0);
    tick(); #1;
    check("t5_hold_req_b", a2x_req, 0);
    check("t5_hold_state", dut.state_q, 0);
    x2a_hold = 1'b0;
    tick(); #1;
    check("t5_grant", a2x_req, 1);
    x2a_hold = 1'b1;
    #1;
    check("t5_locked_noack", x2b_ack, 0);
    tick(); #1;
    check("t5_locked_req", a2x_req, 1);
    check("t5_locked_ba", a2x_ba, 1);
    x2a_ack = 1'b1;
    #1;
    check("t5_locked_ack", x2b_ack, 4'b0010);
    tick(); #1;
    check("t5_after_req", a2x_req, 0);
    tick(); #1;
    check("t5_still_held", a2x_req, 0);
    x2a_hold = 1'b0;
    b2x_req  = 4'b0000;
    #1;
    check("t5_rr", dut.rr_ptr_q, 2);

    // Load tRRD with 9, then reset in the middle of a bank2 grant.
    trrd_delay = 4'd9;
    do_single(1, OP_ACT);
    b2x_cmd = {OP_RD, OP_RD, OP_RD, OP_RD};
    x2a_ack = 1'b0;
    b2x_req = 4'b0100;
    #1;
    tick(); #1;
    check("t6_req", a2x_req, 1);
    check("t6_ba", a2x_ba, 2);
    check("t6_trrd_mid", dut.trrd_cnt_q, 8);
    x2a_ack = 1'b1;
    #1;
    check("t6_ack_pre_rst", x2b_ack, 4'b0100);
    reset = 1'b1;
    #1;
    check("t6_rst_req", a2x_req, 0);
    check("t6_rst_ack", x2b_ack, 0);
    tick();
    reset = 1'b0;
    #1;
    check("t6_gnt", dut.gnt_q, 0);
    check("t6_rr", dut.rr_ptr_q, 0);
    check("t6_trrd", dut.trrd_cnt_q, 0);
    check("t6_state", dut.state_q, 0);
    b2x_req = 4'b0000;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
